berger_one_scrubber: RTL and testbench
======================================

Name: berger_one_scrubber

Overview:
- Background scrub controller placed directly upstream of the Berger-one protected memory (8-bit data, 4-bit address, 16 words).
- Muxes host writes with a sequential read sweep of all 16 addresses and drives the memory's address, data and write-enable inputs.
- Consumes the memory's read data and one_to_zero_error flag, and keeps a per-address error bitmap, an error counter and the first-failing address for software.
- Host writes always win; a host write to a flagged address clears that address's flag, because the write re-encodes the word.

Parameters:
- READ_LATENCY, 1, cycles from address presented to valid mem_err/mem_rdata; legal values 0..3.
- SCRUB_INTERVAL, 256, cycles between automatic sweeps; 0 disables auto-start.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- host_wr_en  input  1  host write strobe
- host_addr  input  4  host write address
- host_data  input  8  host write data
- scrub_start  input  1  one-cycle pulse requesting an immediate sweep
- err_clr  input  1  clears err_map, err_count, first_err_addr, first_err_valid
- mem_addr  output  4  address to memory
- mem_data  output  8  write data to memory (encoder input)
- mem_wr_en  output  1  write enable to memory
- mem_rdata  input  8  decoded read data from memory
- mem_err  input  1  one_to_zero_error from memory decoder
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep completes
- err_map  output  16  bit i set = address i failed its last check
- err_count  output  5  cumulative failures, saturates at 31
- first_err_addr  output  4  address of first failure since clear
- first_err_valid  output  1  first_err_addr is meaningful

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE, the interval counter is 0, and the sweep pointer is 0.
- Write path (combinational pass-through):
  - When host_wr_en=1: mem_wr_en=1, mem_addr=host_addr, mem_data=host_data.
  - Otherwise: mem_wr_en=0, mem_addr=sweep pointer, mem_data=0.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
  - IDLE -> ISSUE when scrub_start=1, or when the interval counter reaches SCRUB_INTERVAL-1 with SCRUB_INTERVAL≠0. The pointer is set to 0 and busy is set on the next cycle.
  - The interval counter increments only in IDLE and clears on entering ISSUE.
  - ISSUE: the address is presented. Load the wait counter with READ_LATENCY, then go to WAIT. If READ_LATENCY=0, go straight to CHECK, sampling in the same cycle.
  - WAIT: decrement the wait counter; go to CHECK when it reaches 0.
  - CHECK: sample mem_err.
    - If 1: set err_map[ptr] and increment err_count (saturating).
    - If 1 and first_err_valid=0: capture first_err_addr=ptr and set first_err_valid.
    - If 0: clear err_map[ptr].
    - If ptr=15, go to DONE; else increment ptr and go to ISSUE.
  - DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- Host collision:
  - Any cycle in ISSUE, WAIT or CHECK with host_wr_en=1 aborts the current check. No sample is taken and no flag or count changes.
  - The FSM returns to ISSUE for the same ptr on the next cycle without host_wr_en. The sweep stalls while host_wr_en stays high.
- Host write clear:
  - host_wr_en=1 clears err_map[host_addr] in every state.
  - It does not change err_count or first_err_addr.
- scrub_start while busy is ignored. Auto-start expiry while busy cannot occur, because the counter is frozen.
- err_clr:
  - Takes effect next cycle.
  - If it coincides with a CHECK failure, the new failure is recorded after the clear: err_count=1, err_map holds only that bit, and first_err_addr is that ptr.
  - It does not affect FSM state.
- rst mid-sweep: everything returns to reset values next cycle; no done pulse.
- mem_rdata is not interpreted; it is used only for bench visibility and port symmetry.

Test Plan:
1. Reset, then scrub_start with a fault-free memory -> busy high for 16×(2+READ_LATENCY) cycles, done pulses once, err_map=0, err_count=0.
2. Write 0xFF to addr 5, force a 1->0 bit flip in stored data, scrub_start -> err_map=0x0020, err_count=1, first_err_addr=5, first_err_valid=1.
3. After scenario 2, host write 0x3C to addr 5 -> err_map=0x0000 while err_count stays 1. Rescrub -> err_count stays 1.
4. Hold host_wr_en for 3 cycles during WAIT for addr 7 -> mem_addr follows host_addr for those cycles, ptr stays 7, addr 7 is re-issued, and total sweep length grows by the stall plus the reissue.
5. SCRUB_INTERVAL=8 with no scrub_start -> sweep begins after 8 idle cycles and repeats after each DONE+8 idle cycles. Inject 2 persistent faults, run 16 sweeps -> err_count saturates at 31.
6. Assert rst at ptr=9 mid-sweep -> next cycle busy=0, err_map=0, no done pulse. err_clr coincident with a CHECK failure at addr 3 -> err_count=1, first_err_addr=3.

Source files
------------

// File: rtl/berger_one_scrubber.sv
// Background scrubber for a 16x8 Berger-one memory: sweeps every address, records
// one-to-zero failures per address, and always yields the memory port to host writes.
//   state   | meaning
//   S_IDLE  | waiting for scrub_start or interval expiry
//   S_ISSUE | sweep address presented to memory
//   S_WAIT  | counting down read latency
//   S_CHECK | sampling mem_err for the current address
//   S_DONE  | one-cycle completion pulse
module berger_one_scrubber #(
    parameter int READ_LATENCY   = 1,
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_wr_en,
    input  logic [3:0]  host_addr,
    input  logic [7:0]  host_data,
    input  logic        scrub_start,
    input  logic        err_clr,
    output logic [3:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr_en,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_map,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_addr,
    output logic        first_err_valid
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [1:0]  LAT      = 2'(READ_LATENCY);
    localparam logic [31:0] INT_LAST = 32'(SCRUB_INTERVAL - 1);
    localparam bit          AUTO_EN  = (SCRUB_INTERVAL != 0);

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [1:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0] int_cnt, int_cnt_nxt;
    logic        sample;

    logic [15:0] map_nxt;
    logic [4:0]  cnt_nxt;
    logic [3:0]  fa_nxt;
    logic        fv_nxt;

    // Read data is not interpreted by the scrubber.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign mem_wr_en = host_wr_en;
    assign mem_addr  = host_wr_en ? host_addr : ptr;
    assign mem_data  = host_wr_en ? host_data : 8'h00;
    assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        wait_cnt_nxt = wait_cnt;
        int_cnt_nxt  = int_cnt;
        sample       = 1'b0;
        case (state)
            S_IDLE: begin
                if (scrub_start || (AUTO_EN && (int_cnt == INT_LAST))) begin
                    state_nxt   = S_ISSUE;
                    ptr_nxt     = 4'd0;
                    int_cnt_nxt = 32'd0;
                end else begin
                    int_cnt_nxt = int_cnt + 32'd1;
                end
            end
            S_ISSUE: begin
                if (!host_wr_en) begin
                    if (LAT == 2'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        wait_cnt_nxt = LAT;
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (host_wr_en) begin
                    state_nxt = S_ISSUE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) begin
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // A host write steals the port, so the read result is discarded and reissued.
                if (host_wr_en) begin
                    state_nxt = S_ISSUE;
                end else begin
                    sample = 1'b1;
                    if (ptr == 4'd15) begin
                        state_nxt = S_DONE;
                    end else begin
                        ptr_nxt   = ptr + 4'd1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Clear first, then record the current sample, so a coincident failure survives err_clr.
    always_comb begin
        map_nxt = err_map;
        cnt_nxt = err_count;
        fa_nxt  = first_err_addr;
        fv_nxt  = first_err_valid;
        if (err_clr) begin
            map_nxt = 16'h0000;
            cnt_nxt = 5'd0;
            fa_nxt  = 4'd0;
            fv_nxt  = 1'b0;
        end
        if (sample) begin
            if (mem_err) begin
                map_nxt[ptr] = 1'b1;
                if (cnt_nxt != 5'd31) begin
                    cnt_nxt = cnt_nxt + 5'd1;
                end
                if (!fv_nxt) begin
                    fa_nxt = ptr;
                    fv_nxt = 1'b1;
                end
            end else begin
                map_nxt[ptr] = 1'b0;
            end
        end
        if (host_wr_en) begin
            map_nxt[host_addr] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr             <= 4'd0;
            wait_cnt        <= 2'd0;
            int_cnt         <= 32'd0;
            err_map         <= 16'h0000;
            err_count       <= 5'd0;
            first_err_addr  <= 4'd0;
            first_err_valid <= 1'b0;
        end else begin
            ptr             <= ptr_nxt;
            wait_cnt        <= wait_cnt_nxt;
            int_cnt         <= int_cnt_nxt;
            err_map         <= map_nxt;
            err_count       <= cnt_nxt;
            first_err_addr  <= fa_nxt;
            first_err_valid <= fv_nxt;
        end
    end

endmodule

// File: tb/tb_berger_one_scrubber.sv
// Bench for berger_one_scrubber: Berger-coded memory model, slot-based reference model
// compared every cycle, directed scenarios, and an auto-interval instance.
module tb_berger_one_scrubber;

    localparam int LAT      = 1;
    localparam int INTERVAL = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_wr_en = 1'b0;
    logic [3:0]  host_addr = 4'd0;
    logic [7:0]  host_data = 8'h00;
    logic        scrub_start = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr_en;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic        busy, done;
    logic [15:0] err_map;
    logic [4:0]  err_count;
    logic [3:0]  first_err_addr;
    logic        first_err_valid;

    logic        rst8 = 1'b1;
    logic [3:0]  mem_addr8;
    logic [7:0]  mem_data8;
    logic        mem_wr_en8;
    logic        mem_err8;
    logic        busy8, done8;
    logic [15:0] err_map8;
    logic [4:0]  err_count8;
    logic [3:0]  fea8;
    logic        fev8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    berger_one_scrubber #(.READ_LATENCY(LAT), .SCRUB_INTERVAL(INTERVAL)) dut (
        .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_addr(host_addr),
        .host_data(host_data), .scrub_start(scrub_start), .err_clr(err_clr),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy), .done(done),
        .err_map(err_map), .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_valid(first_err_valid)
    );

    berger_one_scrubber #(.READ_LATENCY(1), .SCRUB_INTERVAL(8)) dut8 (
        .clk(clk), .rst(rst8), .host_wr_en(1'b0), .host_addr(4'd0),
        .host_data(8'h00), .scrub_start(1'b0), .err_clr(1'b0),
        .mem_addr(mem_addr8), .mem_data(mem_data8), .mem_wr_en(mem_wr_en8),
        .mem_rdata(8'h00), .mem_err(mem_err8), .busy(busy8), .done(done8),
        .err_map(err_map8), .err_count(err_count8), .first_err_addr(fea8),
        .first_err_valid(fev8)
    );

    // Memory: stored word plus Berger check (count of zeros); a 1->0 flip raises the zero count.
    logic [7:0] mem_word [16] = '{default: 8'h00};
    int         mem_code [16] = '{default: 8};
    logic       inj_en = 1'b0;
    logic [3:0] inj_addr = 4'd0;
    logic [7:0] inj_mask = 8'h00;

    function automatic logic word_bad(input logic [3:0] a);
        return $countones(~mem_word[a]) != mem_code[a];
    endfunction

    always @(posedge clk) begin
        mem_err   <= word_bad(mem_addr);
        mem_rdata <= mem_word[mem_addr];
        if (inj_en) mem_word[inj_addr] <= mem_word[inj_addr] & ~inj_mask;
        if (mem_wr_en) begin
            mem_word[mem_addr] <= mem_data;
            mem_code[mem_addr] <= $countones(~mem_data);
        end
        mem_err8 <= (mem_addr8 == 4'd2) || (mem_addr8 == 4'd11);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference: each address occupies a slot of LAT+2 cycles; the last slot cycle is the check.
    bit          m_on = 1'b0;
    bit          m_active = 1'b0, m_done = 1'b0, m_fv = 1'b0, m_chk = 1'b0;
    int          m_ptr = 0, m_step = 0, m_idle = 0, m_cnt = 0, m_fa = 0;
    logic [15:0] m_map = 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_ptr = 0; m_step = 0; m_idle = 0;
            m_map = 16'h0000; m_cnt = 0; m_fa = 0; m_fv = 1'b0;
        end else begin
            m_chk = m_active && !host_wr_en && (m_step == LAT + 1);
            if (err_clr) begin
                m_map = 16'h0000; m_cnt = 0; m_fa = 0; m_fv = 1'b0;
            end
            if (m_chk) begin
                if (mem_err) begin
                    m_map[m_ptr] = 1'b1;
                    if (m_cnt < 31) m_cnt++;
                    if (!m_fv) begin m_fa = m_ptr; m_fv = 1'b1; end
                end else begin
                    m_map[m_ptr] = 1'b0;
                end
            end
            if (host_wr_en) m_map[host_addr] = 1'b0;
            if (m_done) m_done = 1'b0;
            else if (!m_active) begin
                if (scrub_start || (INTERVAL != 0 && m_idle == INTERVAL - 1)) begin
                    m_active = 1'b1; m_ptr = 0; m_step = 0; m_idle = 0;
                end else m_idle++;
            end else if (host_wr_en) m_step = 0;
            else if (m_step == LAT + 1) begin
                if (m_ptr == 15) begin m_active = 1'b0; m_done = 1'b1; end
                else begin m_ptr++; m_step = 0; end
            end else m_step++;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_busy", 32'(busy), 32'(m_active));
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_err_map", 32'(err_map), 32'(m_map));
            chk("model_err_count", 32'(err_count), 32'(m_cnt));
            chk("model_first_err_addr", 32'(first_err_addr), 32'(m_fa));
            chk("model_first_err_valid", 32'(first_err_valid), 32'(m_fv));
            chk("model_mem_wr_en", 32'(mem_wr_en), 32'(host_wr_en));
            chk("model_mem_addr", 32'(mem_addr), 32'(host_wr_en ? host_addr : 4'(m_ptr)));
            chk("model_mem_data", 32'(mem_data), 32'(host_wr_en ? host_data : 8'h00));
        end
    end

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        logic       ewe;
        logic [3:0] ea;
        logic [7:0] ed;
    } wvec_t;
    wvec_t wtab [6];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_wr_en = 1'b1; host_addr = a; host_data = d;
        cyc();
        host_wr_en = 1'b0; host_data = 8'h00;
    endtask

    task automatic inject(input logic [3:0] a, input logic [7:0] m);
        inj_en = 1'b1; inj_addr = a; inj_mask = m;
        cyc();
        inj_en = 1'b0;
    endtask

    task automatic start_sweep();
        scrub_start = 1'b1;
        cyc();
        scrub_start = 1'b0;
    endtask

    task automatic sweep_window(input int w, output int b, output int d);
        b = 0; d = 0;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (busy) b++;
            if (done) d++;
            cyc();
        end
    endtask

    initial begin
        int nb, nd, gap, len;
        wtab[0] = '{1'b1, 4'h5, 8'hFF, 1'b1, 4'h5, 8'hFF};
        wtab[1] = '{1'b0, 4'h5, 8'hFF, 1'b0, 4'h0, 8'h00};
        wtab[2] = '{1'b1, 4'hF, 8'h3C, 1'b1, 4'hF, 8'h3C};
        wtab[3] = '{1'b0, 4'hA, 8'h55, 1'b0, 4'h0, 8'h00};
        wtab[4] = '{1'b1, 4'h0, 8'h81, 1'b1, 4'h0, 8'h81};
        wtab[5] = '{1'b1, 4'h9, 8'h00, 1'b1, 4'h9, 8'h00};

        cyc();
        m_on = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err_map", 32'(err_map), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_first_err_addr", 32'(first_err_addr), 0);
        chk("rst_first_err_valid", 32'(first_err_valid), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            host_wr_en = wtab[i].we; host_addr = wtab[i].a; host_data = wtab[i].d;
            @(negedge clk);
            chk("wtab_wr_en", 32'(mem_wr_en), 32'(wtab[i].ewe));
            chk("wtab_addr", 32'(mem_addr), 32'(wtab[i].ea));
            chk("wtab_data", 32'(mem_data), 32'(wtab[i].ed));
            cyc();
        end
        host_wr_en = 1'b0; host_data = 8'h00;

        // Clean sweep
        start_sweep();
        sweep_window(60, nb, nd);
        chk("s1_busy_cycles", 32'(nb), 32'(16 * (2 + LAT)));
        chk("s1_done_pulses", 32'(nd), 1);
        chk("s1_err_map", 32'(err_map), 0);
        chk("s1_err_count", 32'(err_count), 0);

        // Single fault at address 5
        host_write(4'd5, 8'hFF);
        inject(4'd5, 8'h08);
        start_sweep();
        sweep_window(60, nb, nd);
        chk("s2_err_map", 32'(err_map), 32'h0020);
        chk("s2_err_count", 32'(err_count), 1);
        chk("s2_first_err_addr", 32'(first_err_addr), 5);
        chk("s2_first_err_valid", 32'(first_err_valid), 1);

        // Rewrite clears the flag but not the history
        host_write(4'd5, 8'h3C);
        @(negedge clk);
        chk("s3_map_after_write", 32'(err_map), 0);
        chk("s3_count_after_write", 32'(err_count), 1);
        cyc();
        start_sweep();
        sweep_window(60, nb, nd);
        chk("s3_rescrub_count", 32'(err_count), 1);
        chk("s3_rescrub_map", 32'(err_map), 0);
        chk("s3_rescrub_done", 32'(nd), 1);

        // Host stall during WAIT of address 7
        start_sweep();
        nb = 0; nd = 0;
        for (int i = 0; i < 70; i++) begin
            host_wr_en = (i >= 22 && i <= 24);
            host_addr = 4'd12; host_data = host_wr_en ? 8'hA5 : 8'h00;
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
            if (i == 22 || i == 24) begin
                chk("s4_stall_addr", 32'(mem_addr), 12);
                chk("s4_stall_wr_en", 32'(mem_wr_en), 1);
            end
            if (i == 25) chk("s4_reissue_addr", 32'(mem_addr), 7);
            cyc();
        end
        host_wr_en = 1'b0;
        chk("s4_busy_cycles", 32'(nb), 32'(16 * (2 + LAT) + 4));
        chk("s4_done_pulses", 32'(nd), 1);

        // Reset mid-sweep at ptr 9
        host_write(4'd2, 8'hFF);
        host_write(4'd3, 8'hFF);
        inject(4'd2, 8'h01);
        inject(4'd3, 8'h01);
        start_sweep();
        for (int i = 0; i < 40; i++) begin
            rst = (i == 28);
            @(negedge clk);
            if (i == 28) chk("s6_map_before_rst", 32'(err_map), 32'h000C);
            if (i == 29) begin
                chk("s6_rst_busy", 32'(busy), 0);
                chk("s6_rst_map", 32'(err_map), 0);
                chk("s6_rst_done", 32'(done), 0);
                chk("s6_rst_count", 32'(err_count), 0);
            end
            cyc();
        end
        sweep_window(60, nb, nd);
        chk("s6_no_done_after_rst", 32'(nd), 0);
        chk("s6_no_busy_after_rst", 32'(nb), 0);

        // err_clr coincident with the failing check of address 3
        start_sweep();
        for (int i = 0; i < 60; i++) begin
            err_clr = (i == 11);
            @(negedge clk);
            if (i == 10) chk("s6_pre_clr_fa", 32'(first_err_addr), 2);
            if (i == 12) begin
                chk("s6_clr_count", 32'(err_count), 1);
                chk("s6_clr_fa", 32'(first_err_addr), 3);
                chk("s6_clr_fv", 32'(first_err_valid), 1);
                chk("s6_clr_map", 32'(err_map), 32'h0008);
            end
            cyc();
        end
        err_clr = 1'b0;
        host_write(4'd2, 8'h00);
        host_write(4'd3, 8'h00);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            host_wr_en  = ($urandom_range(0, 4) == 0);
            host_addr   = 4'($urandom);
            host_data   = 8'($urandom);
            scrub_start = ($urandom_range(0, 19) == 0);
            err_clr     = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            inj_en      = ($urandom_range(0, 29) == 0);
            inj_addr    = 4'($urandom);
            inj_mask    = 8'h01 << $urandom_range(0, 7);
            cyc();
        end
        // Quiet traffic so the long interval timer expires
        scrub_start = 1'b0; err_clr = 1'b0; rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            host_wr_en = ($urandom_range(0, 49) == 0);
            host_addr  = 4'($urandom);
            host_data  = 8'($urandom);
            inj_en     = ($urandom_range(0, 99) == 0);
            inj_addr   = 4'($urandom);
            inj_mask   = 8'h01 << $urandom_range(0, 7);
            cyc();
        end
        host_wr_en = 1'b0; host_data = 8'h00; inj_en = 1'b0;

        // Auto-start instance, faults at addresses 2 and 11
        rst8 = 1'b0;
        for (int s = 0; s < 16; s++) begin
            gap = 0;
            @(negedge clk);
            while (!busy8 && gap < 40) begin gap++; @(negedge clk); end
            chk("auto_idle_gap", 32'(gap), 8);
            len = 0;
            while (busy8 && len < 80) begin len++; @(negedge clk); end
            chk("auto_sweep_len", 32'(len), 48);
            chk("auto_done", 32'(done8), 1);
            if (s == 14) chk("auto_count_30", 32'(err_count8), 30);
        end
        chk("auto_count_sat", 32'(err_count8), 31);
        chk("auto_err_map", 32'(err_map8), 32'h0804);
        chk("auto_first_addr", 32'(fea8), 2);
        chk("auto_first_valid", 32'(fev8), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
